// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style interrupt controller.
// PIC_PRIORITY_ROTATION_EN (optional) enables the rotating-priority OCW2 commands.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } pic_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ACK1,
    SEQ_ACK2
  } inta_seq_e;

  // OCW2 R/SL/EOI field (D7:D5)
  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_S_EOI      = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_ROT_S_EOI  = 3'b111;
  localparam logic [2:0] OCW2_SET_PRIO   = 3'b110;

  localparam int ICW1_BIT = 4;
  localparam int LTIM_BIT = 3;
  localparam int SNGL_BIT = 1;
  localparam int IC4_BIT  = 0;
  localparam int AEOI_BIT = 1;
  localparam int RR_BIT   = 1;
  localparam int RIS_BIT  = 0;

  // {found, level} of the first set bit scanning upward from base (wrapping)
  function automatic logic [3:0] first_set(input logic [7:0] vec, input logic [2:0] base);
    logic [3:0] r;
    logic [2:0] l;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      l = base + 3'(i);
      if (vec[l]) r = {1'b1, l};
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Picks the highest-priority unmasked request and flags it when it outranks
// every in-service level; priority starts at base and wraps.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  input  logic [2:0] base,
  output logic [2:0] level,
  output logic       valid
);

  logic [3:0] req, svc;
  logic [2:0] req_off, svc_off;

  assign req     = first_set(irr & ~imr, base);
  assign svc     = first_set(isr, base);
  assign req_off = req[2:0] - base;
  assign svc_off = svc[2:0] - base;
  assign level   = req[2:0];
  assign valid   = req[3] & (~svc[3] | (req_off < svc_off));

endmodule

// File: rtl/pic_top_module.sv
// Programmable interrupt controller: ICW/OCW programming, edge/level IRR,
// two-pulse INTA sequencer, cascade. Optional macro: PIC_PRIORITY_ROTATION_EN.
module pic_top_module
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic       A0,
  input  logic       INTA,
  input  logic       SP_EN,
  input  logic [3:0] CAS,
  input  logic [7:0] IR0_to_IR7,
  output logic       INT,
  inout  wire  [7:0] sys_DataLine
);

  pic_state_e state, state_nxt;
  inta_seq_e  seq;
  logic [7:0] irr, isr, imr, icw3, ir_q, wr_data, ack_mask, isr_clr, rd_val;
  logic [4:0] t_base;
  logic [2:0] prio_base, ack_lvl, win_lvl, rot_val, ocw_cmd, ocw_lvl;
  logic [3:0] isr_top;
  logic ltim, sngl, ic4, aeoi, rd_isr, wr_pend, wr_a0, inta_q;
  logic ack_sel, ack_spur, ack_nodrv, win_vld, rot_load;
  logic commit, ready, is_icw1, is_ocw2, is_ocw3, inta_fall, inta_rise, slave_hit;
  logic rd_drv, vec_drv, unused_cas;

  assign commit    = wr_pend & WR;
  assign ready     = (state == READY);
  assign is_icw1   = commit & ~wr_a0 & wr_data[ICW1_BIT];
  assign is_ocw2   = commit & ~wr_a0 & ready & (wr_data[4:3] == 2'b00);
  assign is_ocw3   = commit & ~wr_a0 & ready & (wr_data[4:3] == 2'b01);
  assign inta_fall = inta_q & ~INTA;
  assign inta_rise = ~inta_q & INTA;
  assign slave_hit = SP_EN | sngl | (CAS[2:0] == icw3[2:0]);
  assign ocw_cmd   = wr_data[7:5];
  assign ocw_lvl   = wr_data[2:0];
  assign isr_top   = first_set(isr, prio_base);
  assign unused_cas = CAS[3];

  pic_priority_resolver u_resolver (
    .irr   (irr),
    .imr   (imr),
    .isr   (isr),
    .base  (prio_base),
    .level (win_lvl),
    .valid (win_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= UNINIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (is_icw1) state_nxt = WAIT_ICW2;
    else if (commit && wr_a0) begin
      case (state)
        WAIT_ICW2: state_nxt = sngl ? (ic4 ? WAIT_ICW4 : READY) : WAIT_ICW3;
        WAIT_ICW3: state_nxt = ic4 ? WAIT_ICW4 : READY;
        WAIT_ICW4: state_nxt = READY;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    ack_mask = '0;
    isr_clr  = '0;
    rot_load = 1'b0;
    rot_val  = prio_base;
    if (ready && seq == SEQ_IDLE && inta_fall && slave_hit && win_vld) ack_mask[win_lvl] = 1'b1;
    if (seq == SEQ_ACK2 && inta_rise && aeoi && ack_sel && !ack_spur) isr_clr[ack_lvl] = 1'b1;
    if (is_ocw2) begin
`ifdef PIC_PRIORITY_ROTATION_EN
      case (ocw_cmd)
        OCW2_NS_EOI: if (isr_top[3]) isr_clr[isr_top[2:0]] = 1'b1;
        OCW2_S_EOI:  isr_clr[ocw_lvl] = 1'b1;
        OCW2_ROT_NS_EOI: if (isr_top[3]) begin
          isr_clr[isr_top[2:0]] = 1'b1;
          rot_load = 1'b1;
          rot_val  = isr_top[2:0] + 3'd1;
        end
        OCW2_ROT_S_EOI: begin
          isr_clr[ocw_lvl] = 1'b1;
          rot_load = 1'b1;
          rot_val  = ocw_lvl + 3'd1;
        end
        OCW2_SET_PRIO: begin
          rot_load = 1'b1;
          rot_val  = ocw_lvl + 3'd1;
        end
        default: ;
      endcase
`else
      case (ocw_cmd)
        OCW2_NS_EOI, OCW2_ROT_NS_EOI: if (isr_top[3]) isr_clr[isr_top[2:0]] = 1'b1;
        OCW2_S_EOI, OCW2_ROT_S_EOI:   isr_clr[ocw_lvl] = 1'b1;
        default: ;
      endcase
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irr <= '0; isr <= '0; imr <= '0; icw3 <= '0; ir_q <= '0; wr_data <= '0;
      t_base <= '0; prio_base <= '0; ack_lvl <= '0;
      ltim <= 1'b0; sngl <= 1'b0; ic4 <= 1'b0; aeoi <= 1'b0; rd_isr <= 1'b0;
      wr_pend <= 1'b0; wr_a0 <= 1'b0; inta_q <= 1'b1;
      ack_sel <= 1'b0; ack_spur <= 1'b0; ack_nodrv <= 1'b0;
      seq <= SEQ_IDLE;
    end else begin
      wr_pend <= ~CS & ~WR;
      if (~CS & ~WR) begin
        wr_data <= sys_DataLine;
        wr_a0   <= A0;
      end
      inta_q <= INTA;
      ir_q   <= IR0_to_IR7;
      // ack clears first so a same-cycle edge stays pending
      irr <= ltim ? (IR0_to_IR7 & ~ack_mask)
                  : ((irr & ~ack_mask) | (IR0_to_IR7 & ~ir_q));
      isr <= (isr & ~isr_clr) | ack_mask;
      if (rot_load) prio_base <= rot_val;

      case (seq)
        SEQ_IDLE: if (ready && inta_fall) begin
          seq       <= SEQ_ACK1;
          ack_sel   <= slave_hit;
          ack_spur  <= ~win_vld;
          ack_lvl   <= win_vld ? win_lvl : 3'd7;
          ack_nodrv <= win_vld & SP_EN & ~sngl & icw3[win_lvl];
        end
        SEQ_ACK1: if (inta_fall) seq <= SEQ_ACK2;
        SEQ_ACK2: if (inta_rise) seq <= SEQ_IDLE;
        default:  seq <= SEQ_IDLE;
      endcase

      if (commit && wr_a0) begin
        case (state)
          WAIT_ICW2: t_base <= wr_data[7:3];
          WAIT_ICW3: icw3   <= wr_data;
          WAIT_ICW4: aeoi   <= wr_data[AEOI_BIT];
          READY:     imr    <= wr_data;
          default: ;
        endcase
      end
      if (is_ocw3 && wr_data[RR_BIT]) rd_isr <= wr_data[RIS_BIT];

      if (is_icw1) begin
        ltim <= wr_data[LTIM_BIT];
        sngl <= wr_data[SNGL_BIT];
        ic4  <= wr_data[IC4_BIT];
        aeoi <= 1'b0;
        imr <= '0; isr <= '0; irr <= '0; ir_q <= '0;
        prio_base <= '0;
        rd_isr <= 1'b0;
        seq <= SEQ_IDLE;
      end
    end
  end

  assign rd_drv  = ~rst & ~CS & ~RD;
  assign vec_drv = ~rst & (seq == SEQ_ACK2) & ~INTA & ack_sel & ~ack_nodrv;
  assign rd_val  = A0 ? imr : (rd_isr ? isr : irr);
  assign sys_DataLine = rd_drv ? rd_val : (vec_drv ? {t_base, ack_lvl} : 8'hzz);
  assign INT = ~rst & ready & win_vld & (seq == SEQ_IDLE);

endmodule

// File: tb/tb_pic_top_module.sv
// Directed bench for pic_top_module; the bus has pullups so an undriven
// bus reads back as 8'hFF.
module tb_pic_top_module;

  logic clk = 1'b0;
  logic rst, CS, RD, WR, A0, INTA, SP_EN, INT;
  logic [3:0] CAS;
  logic [7:0] IR;
  logic [7:0] drv;
  logic drv_en;
  wire  [7:0] sys_DataLine;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign sys_DataLine = drv_en ? drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (sys_DataLine[g]);
  end

  pic_top_module dut (
    .clk(clk), .rst(rst), .CS(CS), .RD(RD), .WR(WR), .A0(A0), .INTA(INTA),
    .SP_EN(SP_EN), .CAS(CAS), .IR0_to_IR7(IR), .INT(INT), .sys_DataLine(sys_DataLine)
  );

  task automatic wr(input logic a0, input logic [7:0] d);
    @(negedge clk); CS = 0; A0 = a0; drv = d; drv_en = 1; WR = 0;
    @(negedge clk); WR = 1;
    @(negedge clk); drv_en = 0; CS = 1;
    @(negedge clk);
  endtask

  task automatic rd(input logic a0, output logic [7:0] v);
    @(negedge clk); CS = 0; A0 = a0; RD = 0;
    #1 v = sys_DataLine;
    @(negedge clk); RD = 1; CS = 1;
  endtask

  task automatic inta_pulse(output logic [7:0] v);
    @(negedge clk); INTA = 0;
    @(negedge clk);
    @(negedge clk); v = sys_DataLine; INTA = 1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_ir(input logic [7:0] m);
    @(negedge clk); IR = m;
    @(negedge clk); IR = 8'h00;
    @(negedge clk);
  endtask

  task automatic init(input logic [7:0] icw1, input logic [7:0] icw4);
    wr(0, icw1); wr(1, 8'h20); wr(1, icw4); wr(1, 8'h00);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1; CS = 0; RD = 0; A0 = 0;
    repeat (3) @(negedge clk);
    n_tests++; if (sys_DataLine !== 8'hFF) begin n_fail++; $display("FAIL rst_bus: got %h want ff", sys_DataLine); end
    n_tests++; if (INT !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %b want 0", INT); end
    CS = 1; RD = 1; rst = 0;
    rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_irr: got %h want 00", v); end
    rd(1, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_imr: got %h want 00", v); end
  endtask

  task automatic test_single;
    logic [7:0] v;
    init(8'h13, 8'h01);
    pulse_ir(8'h08);
    n_tests++; if (INT !== 1'b1) begin n_fail++; $display("FAIL single_int: got %b want 1", INT); end
    rd(0, v);
    n_tests++; if (v !== 8'h08) begin n_fail++; $display("FAIL single_irr: got %h want 08", v); end
    inta_pulse(v);
    n_tests++; if (v !== 8'hFF) begin n_fail++; $display("FAIL single_ack1_bus: got %h want ff", v); end
    inta_pulse(v);
    n_tests++; if (v !== 8'h23) begin n_fail++; $display("FAIL single_vec: got %h want 23", v); end
    n_tests++; if (INT !== 1'b0) begin n_fail++; $display("FAIL single_int_drop: got %b want 0", INT); end
    wr(0, 8'h0B); rd(0, v);
    n_tests++; if (v !== 8'h08) begin n_fail++; $display("FAIL single_isr: got %h want 08", v); end
    wr(0, 8'h20); rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL single_eoi: got %h want 00", v); end
  endtask

  task automatic test_priority;
    logic [7:0] v;
    init(8'h13, 8'h01);
    pulse_ir(8'h24);
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'h22) begin n_fail++; $display("FAIL prio_first: got %h want 22", v); end
    n_tests++; if (INT !== 1'b0) begin n_fail++; $display("FAIL prio_int_blocked: got %b want 0", INT); end
    wr(0, 8'h20);
    n_tests++; if (INT !== 1'b1) begin n_fail++; $display("FAIL prio_int_again: got %b want 1", INT); end
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'h25) begin n_fail++; $display("FAIL prio_second: got %h want 25", v); end
  endtask

  task automatic test_mask;
    logic [7:0] v;
    init(8'h13, 8'h01);
    wr(1, 8'h04);
    @(negedge clk); IR = 8'h04;
    repeat (2) @(negedge clk);
    n_tests++; if (INT !== 1'b0) begin n_fail++; $display("FAIL mask_int: got %b want 0", INT); end
    rd(1, v);
    n_tests++; if (v !== 8'h04) begin n_fail++; $display("FAIL mask_imr: got %h want 04", v); end
    wr(1, 8'h00);
    n_tests++; if (INT !== 1'b1) begin n_fail++; $display("FAIL unmask_int: got %b want 1", INT); end
    IR = 8'h00;
  endtask

  task automatic test_spurious;
    logic [7:0] v;
    init(8'h13, 8'h01);
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'h27) begin n_fail++; $display("FAIL spur_vec: got %h want 27", v); end
    wr(0, 8'h0B); rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL spur_isr: got %h want 00", v); end
  endtask

  task automatic test_specific_eoi;
    logic [7:0] v;
    init(8'h13, 8'h01);
    wr(0, 8'h0B);
    pulse_ir(8'h0A);
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'h21) begin n_fail++; $display("FAIL seoi_vec1: got %h want 21", v); end
    wr(0, 8'h63); rd(0, v);
    n_tests++; if (v !== 8'h02) begin n_fail++; $display("FAIL seoi_wrong_lvl: got %h want 02", v); end
    wr(0, 8'h61); rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL seoi_clear: got %h want 00", v); end
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'h23) begin n_fail++; $display("FAIL seoi_vec2: got %h want 23", v); end
    wr(0, 8'h40); rd(0, v);
    n_tests++; if (v !== 8'h08) begin n_fail++; $display("FAIL ocw2_noop: got %h want 08", v); end
    wr(0, 8'hA0); rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL ocw2_101_eoi: got %h want 00", v); end
  endtask

  task automatic test_aeoi;
    logic [7:0] v;
    init(8'h13, 8'h03);
    pulse_ir(8'h10);
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'h24) begin n_fail++; $display("FAIL aeoi_vec: got %h want 24", v); end
    wr(0, 8'h0B); rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr: got %h want 00", v); end
  endtask

  task automatic test_level;
    logic [7:0] v;
    init(8'h1B, 8'h01);
    @(negedge clk); IR = 8'h02;
    repeat (2) @(negedge clk);
    n_tests++; if (INT !== 1'b1) begin n_fail++; $display("FAIL level_int: got %b want 1", INT); end
    rd(0, v);
    n_tests++; if (v !== 8'h02) begin n_fail++; $display("FAIL level_irr: got %h want 02", v); end
    IR = 8'h00;
    repeat (2) @(negedge clk);
    rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL level_drop: got %h want 00", v); end
    n_tests++; if (INT !== 1'b0) begin n_fail++; $display("FAIL level_int_drop: got %b want 0", INT); end
    IR = 8'h02;
    repeat (2) @(negedge clk);
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'h21) begin n_fail++; $display("FAIL level_vec: got %h want 21", v); end
    IR = 8'h00;
    wr(0, 8'h0B); rd(0, v);
    n_tests++; if (v !== 8'h02) begin n_fail++; $display("FAIL level_isr: got %h want 02", v); end
  endtask

  task automatic test_slave;
    logic [7:0] v;
    SP_EN = 0; CAS = 4'd2;
    wr(0, 8'h11); wr(1, 8'h40); wr(1, 8'h02); wr(1, 8'h01); wr(1, 8'h00);
    pulse_ir(8'h01);
    n_tests++; if (INT !== 1'b1) begin n_fail++; $display("FAIL slave_int: got %b want 1", INT); end
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'h40) begin n_fail++; $display("FAIL slave_hit_vec: got %h want 40", v); end
    wr(0, 8'h20);
    CAS = 4'd3;
    pulse_ir(8'h02);
    inta_pulse(v); inta_pulse(v);
    n_tests++; if (v !== 8'hFF) begin n_fail++; $display("FAIL slave_miss_bus: got %h want ff", v); end
    n_tests++; if (INT !== 1'b1) begin n_fail++; $display("FAIL slave_miss_pending: got %b want 1", INT); end
    SP_EN = 1; CAS = 4'd0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    init(8'h13, 8'h01);
    pulse_ir(8'h01);
    inta_pulse(v);
    @(negedge clk); INTA = 0;
    repeat (2) @(negedge clk);
    n_tests++; if (sys_DataLine !== 8'h20) begin n_fail++; $display("FAIL mid_vec: got %h want 20", sys_DataLine); end
    rst = 1;
    #1;
    n_tests++; if (sys_DataLine !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_bus: got %h want ff", sys_DataLine); end
    @(negedge clk);
    n_tests++; if (INT !== 1'b0) begin n_fail++; $display("FAIL mid_rst_int: got %b want 0", INT); end
    rst = 0; INTA = 1;
    @(negedge clk);
    n_tests++; if (sys_DataLine !== 8'hFF) begin n_fail++; $display("FAIL mid_post_bus: got %h want ff", sys_DataLine); end
    rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_irr: got %h want 00", v); end
    rd(1, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_imr: got %h want 00", v); end
    pulse_ir(8'h01);
    n_tests++; if (INT !== 1'b0) begin n_fail++; $display("FAIL mid_uninit_int: got %b want 0", INT); end
    rd(0, v);
    n_tests++; if (v !== 8'h01) begin n_fail++; $display("FAIL mid_edge_irr: got %h want 01", v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; CS = 1; RD = 1; WR = 1; A0 = 0; INTA = 1; SP_EN = 1;
    CAS = 4'd0; IR = 8'h00; drv = 8'h00; drv_en = 0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_spurious();
    test_specific_eoi();
    test_aeoi();
    test_level();
    test_slave();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
